// File: rtl/run_control_pkg.sv
// Shared types and default parameter values for the run_control block.
package run_control_pkg;

    // ST_ prefix keeps the state literals from clashing with the START/STEP ports
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int DEF_STEP_CYCLES = 1;
    localparam int DEF_MAX_CYCLES  = 0;
    localparam int DEF_COUNT_W     = 32;

endpackage

// File: rtl/run_control_edge_detect.sv
// Rising-edge detector: one history flop, edge = high now and low at the previous clock edge.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic prev;

    // History resets to 0 so a level held high through reset reads as a fresh edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= sig;
    end

    assign rise = sig & ~prev;

endmodule

// File: rtl/run_control.sv
// Run/step/halt controller gating a clock generator, with enabled-cycle counter and watchdog.
module run_control
    import run_control_pkg::*;
#(
    parameter int STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
    parameter int COUNT_W     = DEF_COUNT_W
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               STEP,
    input  logic               HALT,
    input  logic               HALT_INSTR,
    input  logic               CLEAR,
    output logic               ENABLE,
    output logic               RUNNING,
    output logic               STEP_DONE,
    output logic               TIMEOUT,
    output logic [COUNT_W-1:0] CYCLE_COUNT
);

    localparam logic [7:0]         STEP_LAST = 8'(STEP_CYCLES - 1);
    localparam logic [COUNT_W-1:0] MAX_C     = COUNT_W'(MAX_CYCLES);

    state_t             state, state_nxt;
    logic [7:0]         step_cnt, step_cnt_nxt;
    logic [COUNT_W-1:0] count_adv, count_nxt;
    logic               timeout_nxt, step_done_nxt;
    logic               start_rise, step_rise, halt_any, wd_hit;

    edge_detect u_start_edge (.clk(CLOCK), .rst_n(RESET_N), .sig(START), .rise(start_rise));
    edge_detect u_step_edge  (.clk(CLOCK), .rst_n(RESET_N), .sig(STEP),  .rise(step_rise));

    // Counter advances on every edge where the registered enable was high, saturating at all-ones
    assign count_adv = (ENABLE && (CYCLE_COUNT != '1)) ? CYCLE_COUNT + COUNT_W'(1) : CYCLE_COUNT;
    assign halt_any  = HALT | HALT_INSTR;
    assign wd_hit    = (MAX_CYCLES != 0) && ENABLE && (count_adv == MAX_C);

    // Next-state and next-output decode; priority HALT > CLEAR > START > STEP
    always_comb begin
        state_nxt     = state;
        step_cnt_nxt  = step_cnt;
        count_nxt     = count_adv;
        timeout_nxt   = TIMEOUT;
        step_done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                // HALT_INSTR is a decode flag and means nothing while stopped
                if (HALT) begin
                    state_nxt = ST_IDLE;
                end else if (CLEAR) begin
                    count_nxt   = '0;
                    timeout_nxt = 1'b0;
                end else if (start_rise) begin
                    state_nxt = ST_RUN;
                end else if (step_rise) begin
                    state_nxt    = ST_STEP;
                    step_cnt_nxt = 8'd0;
                end
            end
            ST_RUN: begin
                // Watchdog checked first so a coincident halt still records the timeout
                if (wd_hit) begin
                    state_nxt   = ST_HALTED;
                    timeout_nxt = 1'b1;
                end else if (halt_any) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_STEP: begin
                if (wd_hit) begin
                    state_nxt   = ST_HALTED;
                    timeout_nxt = 1'b1;
                end else if (halt_any) begin
                    state_nxt = ST_HALTED;
                end else if (step_cnt == STEP_LAST) begin
                    state_nxt     = ST_IDLE;
                    step_done_nxt = 1'b1;
                end else begin
                    step_cnt_nxt = step_cnt + 8'd1;
                end
            end
            ST_HALTED: begin
                // STEP edges are deliberately ignored here
                if (HALT) begin
                    state_nxt = ST_HALTED;
                end else if (CLEAR) begin
                    state_nxt   = ST_IDLE;
                    count_nxt   = '0;
                    timeout_nxt = 1'b0;
                end else if (start_rise) begin
                    state_nxt   = ST_RUN;
                    timeout_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and all outputs registered straight from the decode, none combinational from inputs
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            step_cnt    <= 8'd0;
            ENABLE      <= 1'b0;
            RUNNING     <= 1'b0;
            STEP_DONE   <= 1'b0;
            TIMEOUT     <= 1'b0;
            CYCLE_COUNT <= '0;
        end else begin
            state       <= state_nxt;
            step_cnt    <= step_cnt_nxt;
            ENABLE      <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
            RUNNING     <= (state_nxt == ST_RUN);
            STEP_DONE   <= step_done_nxt;
            TIMEOUT     <= timeout_nxt;
            CYCLE_COUNT <= count_nxt;
        end
    end

endmodule

// File: tb/tb_run_control.sv
// Directed bench: four run_control configurations share one stimulus set; each test checks its own instance.
module tb_run_control;
    import run_control_pkg::*;

    logic CLOCK, RESET_N, START, STEP, HALT, HALT_INSTR, CLEAR;
    int   total, bad;

    logic a_en, a_run, a_done, a_to; logic [31:0] a_cnt;
    logic b_en, b_run, b_done, b_to; logic [31:0] b_cnt;
    logic c_en, c_run, c_done, c_to; logic [31:0] c_cnt;
    logic d_en, d_run, d_done, d_to; logic [3:0]  d_cnt;

    // A: 3-cycle step, no watchdog
    run_control #(.STEP_CYCLES(3), .MAX_CYCLES(0), .COUNT_W(32)) dut_a (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .STEP(STEP), .HALT(HALT),
        .HALT_INSTR(HALT_INSTR), .CLEAR(CLEAR), .ENABLE(a_en), .RUNNING(a_run),
        .STEP_DONE(a_done), .TIMEOUT(a_to), .CYCLE_COUNT(a_cnt));
    // B: watchdog at 5
    run_control #(.STEP_CYCLES(1), .MAX_CYCLES(5), .COUNT_W(32)) dut_b (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .STEP(STEP), .HALT(HALT),
        .HALT_INSTR(HALT_INSTR), .CLEAR(CLEAR), .ENABLE(b_en), .RUNNING(b_run),
        .STEP_DONE(b_done), .TIMEOUT(b_to), .CYCLE_COUNT(b_cnt));
    // C: 4-cycle step
    run_control #(.STEP_CYCLES(4), .MAX_CYCLES(0), .COUNT_W(32)) dut_c (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .STEP(STEP), .HALT(HALT),
        .HALT_INSTR(HALT_INSTR), .CLEAR(CLEAR), .ENABLE(c_en), .RUNNING(c_run),
        .STEP_DONE(c_done), .TIMEOUT(c_to), .CYCLE_COUNT(c_cnt));
    // D: 4-bit counter
    run_control #(.STEP_CYCLES(1), .MAX_CYCLES(0), .COUNT_W(4)) dut_d (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .STEP(STEP), .HALT(HALT),
        .HALT_INSTR(HALT_INSTR), .CLEAR(CLEAR), .ENABLE(d_en), .RUNNING(d_run),
        .STEP_DONE(d_done), .TIMEOUT(d_to), .CYCLE_COUNT(d_cnt));

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0; START = 1'b0; STEP = 1'b0; HALT = 1'b0; HALT_INSTR = 1'b0; CLEAR = 1'b0;
        tick(); tick();
        RESET_N = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; START = 1'b0; STEP = 1'b0; HALT = 1'b0; HALT_INSTR = 1'b0; CLEAR = 1'b0;
        #1;
        total++;
        if ({a_en, a_run, a_done, a_to, b_en, b_to, c_en, d_en} !== 8'b0 ||
            a_cnt !== 32'd0 || b_cnt !== 32'd0 || c_cnt !== 32'd0 || d_cnt !== 4'd0) begin
            bad++; $display("FAIL reset_outputs a_en=%0b a_cnt=%0d b_cnt=%0d d_cnt=%0d want all 0",
                            a_en, a_cnt, b_cnt, d_cnt);
        end
        tick(); RESET_N = 1'b1; tick();
        total++;
        if (dut_a.state !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut_a.state, ST_IDLE); end
    endtask

    task automatic test_run_halt();
        int miss;
        do_reset();
        START = 1'b1; tick();
        total++;
        if (a_en !== 1'b1 || a_run !== 1'b1 || a_cnt !== 32'd0) begin
            bad++; $display("FAIL run_start en=%0b run=%0b cnt=%0d want 1 1 0", a_en, a_run, a_cnt);
        end
        miss = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            if (a_en !== 1'b1 || a_cnt !== 32'(i)) miss++;
        end
        total++;
        if (miss != 0) begin bad++; $display("FAIL run_hold misses=%0d want 0", miss); end
        HALT = 1'b1; tick();
        total++;
        if (a_en !== 1'b0 || a_run !== 1'b0 || a_cnt !== 32'd10 || dut_a.state !== ST_HALTED) begin
            bad++; $display("FAIL run_halt en=%0b run=%0b cnt=%0d st=%0d want 0 0 10 %0d",
                            a_en, a_run, a_cnt, dut_a.state, ST_HALTED);
        end
        HALT = 1'b0; START = 1'b0; tick();
        STEP = 1'b1; tick();
        total++;
        if (a_en !== 1'b0 || a_cnt !== 32'd10) begin
            bad++; $display("FAIL halted_step_ignored en=%0b cnt=%0d want 0 10", a_en, a_cnt);
        end
        STEP = 1'b0;
    endtask

    task automatic test_step();
        int en_cycles;
        do_reset();
        STEP = 1'b1;
        en_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (a_en === 1'b1 && a_done === 1'b0) en_cycles++;
        end
        total++;
        if (en_cycles != 3) begin bad++; $display("FAIL step_enable cycles=%0d want 3", en_cycles); end
        tick();
        total++;
        if (a_en !== 1'b0 || a_done !== 1'b1 || a_cnt !== 32'd3) begin
            bad++; $display("FAIL step_done en=%0b done=%0b cnt=%0d want 0 1 3", a_en, a_done, a_cnt);
        end
        tick();
        total++;
        if (a_done !== 1'b0 || a_en !== 1'b0) begin
            bad++; $display("FAIL step_pulse_width done=%0b en=%0b want 0 0", a_done, a_en);
        end
        STEP = 1'b0;
    endtask

    task automatic test_watchdog();
        do_reset();
        START = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (b_en !== 1'b1 || b_cnt !== 32'd4 || b_to !== 1'b0) begin
            bad++; $display("FAIL wd_before en=%0b cnt=%0d to=%0b want 1 4 0", b_en, b_cnt, b_to);
        end
        tick();
        total++;
        if (b_en !== 1'b0 || b_to !== 1'b1 || b_cnt !== 32'd5 || b_done !== 1'b0) begin
            bad++; $display("FAIL wd_fire en=%0b to=%0b cnt=%0d done=%0b want 0 1 5 0", b_en, b_to, b_cnt, b_done);
        end
        START = 1'b0; tick(); START = 1'b1; tick();
        total++;
        if (b_to !== 1'b0 || b_run !== 1'b1 || b_cnt !== 32'd5) begin
            bad++; $display("FAIL wd_resume to=%0b run=%0b cnt=%0d want 0 1 5", b_to, b_run, b_cnt);
        end
        tick();
        total++;
        if (b_cnt !== 32'd6 || b_en !== 1'b1) begin
            bad++; $display("FAIL wd_resume_count cnt=%0d en=%0b want 6 1", b_cnt, b_en);
        end
        START = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        HALT = 1'b1; START = 1'b1; tick();
        total++;
        if (a_en !== 1'b0) begin bad++; $display("FAIL prio_halt_start en=%0b want 0", a_en); end
        HALT = 1'b0; tick(); tick();
        total++;
        if (a_en !== 1'b0 || a_run !== 1'b0) begin
            bad++; $display("FAIL prio_no_late_run en=%0b run=%0b want 0 0", a_en, a_run);
        end
        START = 1'b0; HALT_INSTR = 1'b1; tick();
        START = 1'b1; tick();
        total++;
        if (a_run !== 1'b1) begin bad++; $display("FAIL haltinstr_idle run=%0b want 1", a_run); end
        tick();
        total++;
        if (a_en !== 1'b0 || a_cnt !== 32'd1 || dut_a.state !== ST_HALTED) begin
            bad++; $display("FAIL haltinstr_run en=%0b cnt=%0d st=%0d want 0 1 %0d", a_en, a_cnt, dut_a.state, ST_HALTED);
        end
        HALT_INSTR = 1'b0; CLEAR = 1'b1; tick();
        total++;
        if (a_cnt !== 32'd0 || dut_a.state !== ST_IDLE || a_en !== 1'b0) begin
            bad++; $display("FAIL clear_halted cnt=%0d st=%0d en=%0b want 0 %0d 0", a_cnt, dut_a.state, a_en, ST_IDLE);
        end
        CLEAR = 1'b0; START = 1'b0;
    endtask

    task automatic test_reset_mid_step();
        do_reset();
        STEP = 1'b1; tick(); tick(); tick();
        total++;
        if (c_en !== 1'b1 || c_cnt !== 32'd2) begin
            bad++; $display("FAIL midstep_pre en=%0b cnt=%0d want 1 2", c_en, c_cnt);
        end
        #2; RESET_N = 1'b0; #1;
        total++;
        if ({c_en, c_run, c_done, c_to} !== 4'b0 || c_cnt !== 32'd0 || dut_c.state !== ST_IDLE) begin
            bad++; $display("FAIL midstep_async en=%0b done=%0b cnt=%0d want 0 0 0", c_en, c_done, c_cnt);
        end
        tick();
        total++;
        if (c_done !== 1'b0 || c_en !== 1'b0) begin
            bad++; $display("FAIL midstep_no_done done=%0b en=%0b want 0 0", c_done, c_en);
        end
        RESET_N = 1'b1; tick();
        total++;
        if (c_en !== 1'b1) begin bad++; $display("FAIL held_step_edge en=%0b want 1", c_en); end
        STEP = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        START = 1'b1; tick();
        for (int i = 0; i < 15; i++) tick();
        total++;
        if (d_cnt !== 4'd15) begin bad++; $display("FAIL sat_reach cnt=%0d want 15", d_cnt); end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (d_cnt !== 4'd15 || d_en !== 1'b1) begin
            bad++; $display("FAIL sat_hold cnt=%0d en=%0b want 15 1", d_cnt, d_en);
        end
        START = 1'b0;
    endtask

    initial begin
        total = 0; bad = 0;
        RESET_N = 1'b0; START = 1'b0; STEP = 1'b0; HALT = 1'b0; HALT_INSTR = 1'b0; CLEAR = 1'b0;
        test_reset();
        test_run_halt();
        test_step();
        test_watchdog();
        test_priority();
        test_reset_mid_step();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 SHALL expose parameter STEP_CYCLES, default 1, meaning the number of enabled cycles per single-step request; legal range 1..255.
REQ-002 SHALL expose parameter MAX_CYCLES, default 0, meaning the watchdog limit on enabled cycles; 0 disables the watchdog.
REQ-003 SHALL expose parameter COUNT_W, default 32, meaning the width of CYCLE_COUNT.
REQ-004 SHALL have port CLOCK, input, 1, the single system clock; all state updates occur on its rising edge.
REQ-005 SHALL have port RESET_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port START, input, 1, level request to run; acts on its rising edge.
REQ-007 SHALL have port STEP, input, 1, level request to single-step; acts on its rising edge.
REQ-008 SHALL have port HALT, input, 1, level halt request; acts while high.
REQ-009 SHALL have port HALT_INSTR, input, 1, CPU decode flag for a halt instruction; acts while high, and only in RUN or STEP.
REQ-010 SHALL have port CLEAR, input, 1, level request to clear the count and return to IDLE.
REQ-011 SHALL have port ENABLE, output, 1, registered enable driven to the clock generator's ENABLE input.
REQ-012 SHALL have port RUNNING, output, 1, high while in the RUN state.
REQ-013 SHALL have port STEP_DONE, output, 1, one-cycle pulse marking completion of a step.
REQ-014 SHALL have port TIMEOUT, output, 1, sticky flag set when the watchdog halts the block.
REQ-015 SHALL have port CYCLE_COUNT, output, COUNT_W, the count of enabled cycles.

Function
REQ-016 SHALL implement an FSM with exactly four states: IDLE, RUN, STEP, HALTED.
REQ-017 SHALL define an edge on START or STEP as: sampled high at edge k and sampled low at edge k-1; the resulting state and outputs change at edge k.
REQ-018 SHALL, in IDLE, hold ENABLE at 0, go to RUN on a START edge, and go to STEP on a STEP edge; START SHALL win if both edges occur together.
REQ-019 SHALL, in RUN, hold ENABLE at 1 and go to HALTED when HALT or HALT_INSTR is high.
REQ-020 SHALL, in STEP, hold ENABLE at 1 for exactly STEP_CYCLES cycles, then go to IDLE and pulse STEP_DONE on the same edge at which ENABLE falls.
REQ-021 SHALL, when HALT or HALT_INSTR is high during STEP, go to HALTED with no STEP_DONE pulse.
REQ-022 SHALL, in HALTED, hold ENABLE at 0, resume RUN on a START edge with CYCLE_COUNT preserved and TIMEOUT cleared, and ignore STEP edges.
REQ-023 SHALL, in IDLE or HALTED, zero CYCLE_COUNT and TIMEOUT and go to IDLE on CLEAR; CLEAR SHALL be ignored in RUN and STEP.
REQ-024 SHALL apply per-edge priority HALT/HALT_INSTR > CLEAR > START > STEP.
REQ-025 SHALL ignore a START or STEP edge that occurs while HALT is high; that edge SHALL NOT be acted on later.
REQ-026 SHALL increment CYCLE_COUNT by 1 at every edge where ENABLE was 1 before the edge.
REQ-027 SHALL saturate CYCLE_COUNT at 2^COUNT_W-1 and never wrap.
REQ-028 SHALL, when MAX_CYCLES is nonzero and CYCLE_COUNT becomes MAX_CYCLES at an edge in RUN or STEP, go to HALTED with TIMEOUT=1, ENABLE=0 and no STEP_DONE, on that same edge.
REQ-029 SHALL register ENABLE, RUNNING and STEP_DONE directly from the FSM with no combinational path from any input.

Reset
REQ-030 SHALL, while RESET_N=0, immediately force the state to IDLE, ENABLE=0, RUNNING=0, STEP_DONE=0, TIMEOUT=0, CYCLE_COUNT=0 and the edge-detector history to 0.
REQ-031 SHALL, when reset is asserted mid-RUN or mid-STEP, drop ENABLE asynchronously and emit no STEP_DONE pulse.
REQ-032 SHALL require a fresh START or STEP edge after RESET_N deassertion; a START held high through reset SHALL be seen as an edge at the first edge after reset.

Structure
REQ-033 SHALL place the state enum type (IDLE, RUN, STEP, HALTED) and the default parameter constants in the shared package run_control_pkg.
REQ-034 SHALL instantiate one sub-module, edge_detect: a registered rising-edge detector used once for START and once for STEP.

Verification
REQ-035 SHALL verify run and halt: START rising at cycle 2, HALT high at cycle 12 -> ENABLE high for cycles 2-11, CYCLE_COUNT=10, state HALTED.
REQ-036 SHALL verify step with STEP_CYCLES=3: STEP edge in IDLE -> ENABLE high for exactly 3 cycles, one STEP_DONE pulse when ENABLE falls, CYCLE_COUNT=3.
REQ-037 SHALL verify the watchdog with MAX_CYCLES=5: START edge -> ENABLE high for 5 cycles, TIMEOUT=1, CYCLE_COUNT=5; a further START edge -> TIMEOUT=0 and RUN resumes.
REQ-038 SHALL verify priority: HALT and a START edge on the same edge in IDLE -> ENABLE stays 0 and no later RUN occurs; CLEAR in HALTED -> CYCLE_COUNT=0 and state IDLE.
REQ-039 SHALL verify reset mid-step with STEP_CYCLES=4: RESET_N low after 2 enabled cycles -> ENABLE=0 immediately, no STEP_DONE, all outputs at reset values.
REQ-040 SHALL verify saturation with COUNT_W=4: a continuous 20-cycle RUN -> CYCLE_COUNT holds at 15.
